mini_core_dmem_ctrl: RTL

MINI_CORE_DMEM_CTRL -- requirements
Module: mini_core_dmem_ctrl

---
 rtl/mini_core_dmem_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mini_core_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mini_core_dmem_ctrl
// Brief    : Data-memory port arbiter between the core pipeline (Q103H) and an
//            external debug/loader requester. Issues one request at a time,
//            tracks one outstanding read, and returns zero data with an error
//            pulse if the read response does not arrive in time.
// Revision : 1.0  initial release
// ============================================================================
module mini_core_dmem_ctrl #(
    parameter int TIMEOUT    = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic        Clock,
    input  logic        RstN,
    input  logic        CoreReqValid,
    input  logic        CoreReqWr,
    input  logic [31:0] CoreReqAddr,
    input  logic [31:0] CoreReqData,
    input  logic [3:0]  CoreReqByteEn,
    input  logic        ExtReqValid,
    input  logic        ExtReqWr,
    input  logic [31:0] ExtReqAddr,
    input  logic [31:0] ExtReqData,
    input  logic [3:0]  ExtReqByteEn,
    output logic        ExtReqReady,
    output logic        CoreStall,
    output logic        DMemReqValid,
    output logic        DMemReqWr,
    output logic [31:0] DMemReqAddr,
    output logic [31:0] DMemReqData,
    output logic [3:0]  DMemByteEn,
    input  logic        DMemReady,
    input  logic        DMemRdRspValid,
    input  logic [31:0] DMemRdRspData,
    output logic        CoreRdRspValid,
    output logic        ExtRdRspValid,
    output logic [31:0] RdRspData,
    output logic        TimeoutErr
);

    localparam logic [1:0] c_IDLE         = 2'd0;
    localparam logic [1:0] c_RD_WAIT_CORE = 2'd1;
    localparam logic [1:0] c_RD_WAIT_EXT  = 2'd2;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
    localparam logic [7:0] c_WAIT_LAST  = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic [7:0] wait_q, wait_d;

    logic w_wait_core, w_wait_ext, w_waiting, w_idle;
    logic w_grant_ext, w_grant_core, w_issue, w_accept;
    logic w_core_acc, w_ext_acc, w_wr;
    logic w_rsp, w_timeout, w_done;

    // State decode; the unused encoding behaves as IDLE and is steered back.
    assign w_wait_core = (state_q == c_RD_WAIT_CORE);
    assign w_wait_ext  = (state_q == c_RD_WAIT_EXT);
    assign w_waiting   = w_wait_core | w_wait_ext;
    assign w_idle      = ~w_waiting;

    // Core has priority unless the external requester has been starved long enough.
    assign w_grant_ext  = ExtReqValid & (~CoreReqValid | (starve_q == c_STARVE_MAX));
    assign w_grant_core = CoreReqValid & ~w_grant_ext;
    assign w_issue      = w_idle & (w_grant_core | w_grant_ext);
    assign w_accept     = w_issue & DMemReady;
    assign w_core_acc   = w_accept & w_grant_core;
    assign w_ext_acc    = w_accept & w_grant_ext;
    assign w_wr         = w_grant_ext ? ExtReqWr : CoreReqWr;

    // A real response wins over a coincident timeout.
    assign w_rsp     = w_waiting & DMemRdRspValid;
    assign w_timeout = w_waiting & ~DMemRdRspValid & (wait_q == c_WAIT_LAST);
    assign w_done    = w_rsp | w_timeout;

    // Memory request bus, forced to zero while reset is asserted.
    assign DMemReqValid = RstN & w_issue;
    assign DMemReqWr    = RstN & w_issue & w_wr;
    assign DMemReqAddr  = (RstN & w_issue) ? (w_grant_ext ? ExtReqAddr : CoreReqAddr) : 32'h0;
    assign DMemReqData  = (RstN & w_issue) ? (w_grant_ext ? ExtReqData : CoreReqData) : 32'h0;
    assign DMemByteEn   = (RstN & w_issue) ? (w_grant_ext ? ExtReqByteEn : CoreReqByteEn) : 4'h0;

    // Requester-facing handshakes and read return path.
    assign ExtReqReady    = RstN & w_ext_acc;
    assign CoreRdRspValid = RstN & w_wait_core & w_done;
    assign ExtRdRspValid  = RstN & w_wait_ext & w_done;
    assign RdRspData      = (RstN & w_rsp) ? DMemRdRspData : 32'h0;
    assign TimeoutErr     = RstN & w_timeout;
    assign CoreStall      = RstN & ~(w_wait_core & w_done) &
                            (w_wait_core | (CoreReqValid & ~w_core_acc));

    // Next-state logic for the FSM, starvation counter and wait counter.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        wait_d   = wait_q;

        case (state_q)
            c_IDLE: begin
                if (w_accept && !w_wr) begin
                    state_d = w_grant_ext ? c_RD_WAIT_EXT : c_RD_WAIT_CORE;
                    wait_d  = 8'd0;
                end
            end
            c_RD_WAIT_CORE, c_RD_WAIT_EXT: begin
                if (w_done) begin
                    state_d = c_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (!ExtReqValid || w_ext_acc) begin
            starve_d = 4'd0;
        end else if (w_core_acc && (starve_q != c_STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge RstN) begin
        if (!RstN) begin
            state_q  <= c_IDLE;
            starve_q <= 4'd0;
            wait_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
        end
    end

endmodule
`default_nettype wire
